// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer: round-robin or fixed-priority grant feeding a
// registered valid/ready output stage.
module rr_arb_mux #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic                         prio_mode,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CH_W-1:0]       r_out_ch;
  logic                  r_out_valid;
  logic [CH_W-1:0]       r_ptr;

  logic                  w_any;
  logic                  w_load;
  logic                  w_hs;
  logic [CH_W-1:0]       w_rr_hi;
  logic                  w_rr_hi_found;
  logic [CH_W-1:0]       w_rr_lo;
  logic [CH_W-1:0]       w_fp_grant;
  logic [CH_W-1:0]       w_grant;
  logic [DATA_WIDTH-1:0] w_grant_data;

  assign w_any  = |in_valid;
  assign w_load = !r_out_valid || out_ready;
  assign w_hs   = w_load && w_any && !reset;

  // Round-robin: lowest requester above ptr if any, otherwise lowest at or below ptr.
  // Descending loops let the lowest qualifying index win.
  always_comb begin
    w_rr_hi       = '0;
    w_rr_hi_found = 1'b0;
    w_rr_lo       = '0;
    w_fp_grant    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        w_fp_grant = CH_W'(i);
        if (CH_W'(i) > r_ptr) begin
          w_rr_hi       = CH_W'(i);
          w_rr_hi_found = 1'b1;
        end else begin
          w_rr_lo = CH_W'(i);
        end
      end
    end
  end

  always_comb begin
    if (prio_mode) begin
      w_grant = w_fp_grant;
    end else if (w_rr_hi_found) begin
      w_grant = w_rr_hi;
    end else begin
      w_grant = w_rr_lo;
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == w_grant) begin
        w_grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_hs && (CH_W'(i) == w_grant)) begin
        in_ready[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= CH_W'(NUM_CH - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_ch    <= w_grant;
        r_ptr       <= w_grant;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
